// File: rtl/hex_display_ctrl.sv
// Binary-to-7-segment controller: double-dabble conversion of a WIDTH-bit value
// into six active-low HEX digit patterns, with optional leading-zero blanking.
module hex_display_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);
    // state     | meaning
    // S_IDLE    | waiting for start; HEX outputs hold last result
    // S_CONVERT | one shift-and-add-3 step per cycle, WIDTH steps total
    // S_LOAD    | decode BCD into the HEX registers and pulse done
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_LOAD    = 2'd2;

    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shift;
    logic [23:0]      bcd;
    logic [23:0]      bcd_adj;
    logic [CW-1:0]    cnt;
    logic             blank_q;
    logic [6:0]       hex_q    [6];
    logic [6:0]       hex_next [6];

    // Active-high segment table {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Walk from the most significant digit down so each digit knows whether
    // everything above it is zero; the ones digit is never blanked.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            zero_above = zero_above && (bcd[4*i +: 4] == 4'd0);
            if (i != 0 && blank_q && zero_above)
                hex_next[i] = 7'b1111111;
            else
                hex_next[i] = ~seg7(bcd[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            shift   <= '0;
            bcd     <= '0;
            cnt     <= '0;
            blank_q <= 1'b0;
            for (int i = 0; i < 6; i++) hex_q[i] <= 7'b1111111;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_CONVERT;
                        busy    <= 1'b1;
                        shift   <= value;
                        bcd     <= '0;
                        cnt     <= '0;
                        blank_q <= blank_lz;
                    end
                end
                S_CONVERT: begin
                    bcd   <= {bcd_adj[22:0], shift[WIDTH-1]};
                    shift <= shift << 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) state <= S_LOAD;
                end
                S_LOAD: begin
                    for (int i = 0; i < 6; i++) hex_q[i] <= hex_next[i];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl (WIDTH=16): timing, decode, blanking,
// ignored starts, back-to-back throughput and reset abort.
module tb_hex_display_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] value;
    logic        blank_lz;
    logic        busy, done;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                           D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                           D6 = 7'b0000010, D7 = 7'b1111000, D8 = 7'b0000000;

    hex_display_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .value(value),
        .blank_lz(blank_lz), .busy(busy), .done(done),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] hexes();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    // One conversion: checks busy length, done pulse width and the result.
    task automatic convert(input string tag, input logic [15:0] v, input logic b,
                           input logic [41:0] exp_hex);
        int n;
        @(negedge clk);
        value = v; blank_lz = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; value = 16'hFFFF; blank_lz = ~b;
        n = 1;
        while (busy && n < 100) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk({tag, "_busy_cycles"}, n, 17);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_hex"}, hexes(), exp_hex);
        @(negedge clk);
        chk({tag, "_done_drop"}, done, 1'b0);
        chk({tag, "_hex_hold"}, hexes(), exp_hex);
    endtask

    initial begin
        int n, pulses, t0, t1;
        reset_n = 1'b0; start = 1'b1; value = 16'd123; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hex", hexes(), {6{BL}});
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        start = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_busy", busy, 1'b0);
        chk("rel_hex", hexes(), {6{BL}});

        convert("c12345", 16'd12345, 1'b0, {D0, D1, D2, D3, D4, D5});
        convert("c42", 16'd42, 1'b1, {BL, BL, BL, BL, D4, D2});
        convert("c0", 16'd0, 1'b1, {BL, BL, BL, BL, BL, D0});
        convert("c65535", 16'd65535, 1'b1, {BL, D6, D5, D5, D3, D5});

        // Start with 7, then a second start 3 edges later must be ignored.
        @(negedge clk);
        value = 16'd7; blank_lz = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        value = 16'd9; blank_lz = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_hex", hexes(), {D0, D0, D0, D0, D0, D7});

        // Held start: measure spacing between consecutive done pulses.
        value = 16'd5; blank_lz = 1'b0; start = 1'b1;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        t0 = n;
        @(negedge clk); n++;
        while (!done && n < 200) begin @(negedge clk); n++; end
        t1 = n;
        chk("b2b_period", t1 - t0, 18);
        chk("b2b_hex", hexes(), {D0, D0, D0, D0, D0, D5});
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Reset 5 cycles into a conversion aborts it.
        value = 16'd321; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("abort_hex", hexes(), {6{BL}});
        chk("abort_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("abort_no_done", pulses, 0);
        convert("c8", 16'd8, 1'b0, {D0, D0, D0, D0, D0, D8});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
